// File: rtl/dfa_state_ram_mp.sv
// Multiport DFA state RAM: one write port, NUM_RD read ports with write lookahead and soft-clear sweep.
// Optional macro DFA_STATE_RAM_MP_OUTREG_EN adds a per-port output register (read latency 2).
module dfa_state_ram_mp_rdport #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  input  logic [DATA_WIDTH-1:0] i_mem_data,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_wr_acc,
  output logic [DATA_WIDTH-1:0] o_rd_data
);
  logic                  r_byp;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_mem_q;
  logic [DATA_WIDTH-1:0] w_stage1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_byp   <= 1'b0;
      r_wdata <= '0;
      r_mem_q <= '0;
    end else begin
      r_byp   <= (i_rd_addr == i_wr_addr) && i_wr_acc;
      r_wdata <= i_wr_data;
      r_mem_q <= i_mem_data;
    end
  end

  assign w_stage1 = r_byp ? r_wdata : r_mem_q;

`ifdef DFA_STATE_RAM_MP_OUTREG_EN
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [DATA_WIDTH-1:0] r_out;

  // A write landing one cycle after the address was sampled is younger than anything stage 1 saw.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_addr <= '0;
      r_out     <= '0;
    end else begin
      r_rd_addr <= i_rd_addr;
      r_out     <= ((r_rd_addr == i_wr_addr) && i_wr_acc) ? i_wr_data : w_stage1;
    end
  end

  assign o_rd_data = r_out;
`else
  assign o_rd_data = w_stage1;
`endif
endmodule

module dfa_state_ram_mp #(
  parameter int DEPTH          = 16,
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int NUM_RD         = 2,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [ADDR_WIDTH-1:0]        wr_address,
  input  logic [DATA_WIDTH-1:0]        wr_writedata,
  input  logic                         wr_write,
  output logic                         wr_waitrequest,
  input  logic                         clear,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_address,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_readdata
);
  localparam int                  IW      = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LP_LAST = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {S_CLEARING, S_READY} state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_clear_count;
  logic                  r_waitreq;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                                   w_wr_acc;
  logic                                   w_wr_inrange;
  logic [NUM_RD-1:0][ADDR_WIDTH-1:0]      w_rd_addr;
  logic [NUM_RD-1:0][DATA_WIDTH-1:0]      w_mem_rd;
  logic [NUM_RD-1:0][DATA_WIDTH-1:0]      w_rd_data;

  assign w_wr_acc       = wr_write && !r_waitreq;
  assign w_wr_inrange   = {1'b0, wr_address} < LP_DEPTH;
  assign wr_waitrequest = r_waitreq;
  assign w_rd_addr      = rd_address;
  assign rd_readdata    = w_rd_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= (CLEAR_ON_RESET != 0) ? S_CLEARING : S_READY;
      r_clear_count <= LP_LAST;
      r_waitreq     <= 1'b1;
    end else begin
      case (r_state)
        S_CLEARING: begin
          if (r_clear_count == '0) begin
            r_state   <= S_READY;
            r_waitreq <= 1'b0;
          end else begin
            r_clear_count <= r_clear_count - 1'b1;
          end
        end
        default: begin
          r_waitreq <= 1'b0;
          if (clear && (CLEAR_ON_RESET != 0)) begin
            r_state       <= S_CLEARING;
            r_clear_count <= LP_LAST;
            r_waitreq     <= 1'b1;
          end
        end
      endcase
    end
  end

  // Storage has no reset; the sweep is what zeroes it.
  always_ff @(posedge clk) begin
    if (r_state == S_CLEARING)
      r_mem[r_clear_count[IW-1:0]] <= '0;
    else if (w_wr_acc && w_wr_inrange)
      r_mem[wr_address[IW-1:0]] <= wr_writedata;
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    assign w_mem_rd[k] = ({1'b0, w_rd_addr[k]} < LP_DEPTH) ? r_mem[w_rd_addr[k][IW-1:0]] : '0;

    dfa_state_ram_mp_rdport #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_rdport (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_rd_addr  (w_rd_addr[k]),
      .i_mem_data (w_mem_rd[k]),
      .i_wr_addr  (wr_address),
      .i_wr_data  (wr_writedata),
      .i_wr_acc   (w_wr_acc),
      .o_rd_data  (w_rd_data[k])
    );
  end
endmodule

// File: tb/tb_dfa_state_ram_mp.sv
// Directed bench for dfa_state_ram_mp: sweep timing, lookahead, clear, out-of-range and mid-sweep reset.
module tb_dfa_state_ram_mp;
  localparam int AW = 5;
  localparam int DW = 8;
`ifdef DFA_STATE_RAM_MP_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic            clk = 1'b0;
  logic            reset_n;
  logic [AW-1:0]   wr_address;
  logic [DW-1:0]   wr_writedata;
  logic            wr_write;
  logic            wr_waitrequest;
  logic            clear;
  logic [2*AW-1:0] rd_address;
  logic [2*DW-1:0] rd_readdata;

  int errors = 0;
  int checks = 0;

  dfa_state_ram_mp #(
    .DEPTH(16), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(2), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .wr_address(wr_address), .wr_writedata(wr_writedata), .wr_write(wr_write),
    .wr_waitrequest(wr_waitrequest), .clear(clear),
    .rd_address(rd_address), .rd_readdata(rd_readdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_rd(input int a0, input int a1);
    rd_address = {AW'(a1), AW'(a0)};
  endtask

  task automatic sweep_timing(input string nm);
    for (int k = 1; k <= 16; k++) begin
      step();
      checks++;
      if (wr_waitrequest !== (k < 16)) begin
        errors++;
        $display("FAIL %s edge %0d: waitrequest=%b want %b", nm, k, wr_waitrequest, (k < 16));
      end
    end
  endtask

  task automatic all_zero(input string nm);
    for (int a = 0; a < 16; a++) begin
      set_rd(a, 15 - a);
      repeat (LAT) step();
      checks++;
      if (rd_readdata !== 16'h0000) begin
        errors++;
        $display("FAIL %s addr %0d: readdata=%h want 0000", nm, a, rd_readdata);
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; wr_address = '0; wr_writedata = '0; wr_write = 1'b0;
    clear = 1'b0; set_rd(0, 0);
    repeat (2) step();
    checks++;
    if (wr_waitrequest !== 1'b1 || rd_readdata !== 16'h0) begin
      errors++;
      $display("FAIL reset_state: waitreq=%b rd=%h want 1/0000", wr_waitrequest, rd_readdata);
    end
    reset_n = 1'b1;
    sweep_timing("reset_sweep");
    all_zero("reset_read");
  endtask

  task automatic test_write_bypass();
    wr_address = 5'd3; wr_writedata = 8'hA5; wr_write = 1'b1;
    set_rd(3, 4);
    step();
    wr_write = 1'b0;
    repeat (LAT - 1) step();
    checks++;
    if (rd_readdata !== 16'h00A5) begin
      errors++;
      $display("FAIL write_bypass: rd=%h want 00A5", rd_readdata);
    end
    set_rd(3, 3);
    repeat (LAT) step();
    checks++;
    if (rd_readdata !== 16'hA5A5) begin
      errors++;
      $display("FAIL write_idle_read: rd=%h want A5A5", rd_readdata);
    end
  endtask

  task automatic test_back_to_back();
`ifndef DFA_STATE_RAM_MP_OUTREG_EN
    logic [7:0] vals [3];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    set_rd(7, 7);
    step();
    for (int i = 0; i < 3; i++) begin
      wr_address = 5'd7; wr_writedata = vals[i]; wr_write = 1'b1;
      step();
      checks++;
      if (rd_readdata !== {vals[i], vals[i]}) begin
        errors++;
        $display("FAIL back_to_back %0d: rd=%h want %h", i, rd_readdata, {vals[i], vals[i]});
      end
    end
    wr_write = 1'b0;
    step();
    checks++;
    if (rd_readdata !== 16'h3333) begin
      errors++;
      $display("FAIL back_to_back_mem: rd=%h want 3333", rd_readdata);
    end
`endif
  endtask

  task automatic test_out_of_range();
    wr_address = 5'd20; wr_writedata = 8'h77; wr_write = 1'b1;
    set_rd(20, 4);
    step();
    wr_write = 1'b0;
    repeat (LAT - 1) step();
    checks++;
    if (rd_readdata !== 16'h0077) begin
      errors++;
      $display("FAIL oor_bypass: rd=%h want 0077", rd_readdata);
    end
    repeat (LAT) step();
    checks++;
    if (rd_readdata !== 16'h0000) begin
      errors++;
      $display("FAIL oor_dropped: rd=%h want 0000", rd_readdata);
    end
  endtask

  task automatic test_clear();
    for (int a = 0; a < 16; a++) begin
      checks++;
      if (wr_waitrequest !== 1'b0) begin
        errors++;
        $display("FAIL fill_waitreq addr %0d: waitreq=%b want 0", a, wr_waitrequest);
      end
      wr_address = AW'(a); wr_writedata = DW'(a + 1); wr_write = 1'b1;
      step();
    end
    wr_write = 1'b0;
    set_rd(5, 15);
    repeat (LAT) step();
    checks++;
    if (rd_readdata !== 16'h1006) begin
      errors++;
      $display("FAIL fill_read: rd=%h want 1006", rd_readdata);
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    checks++;
    if (wr_waitrequest !== 1'b1) begin
      errors++;
      $display("FAIL clear_start: waitreq=%b want 1", wr_waitrequest);
    end
    for (int k = 1; k <= 16; k++) begin
      if (k == 3) begin
        wr_address = 5'd15; wr_writedata = 8'hFF; wr_write = 1'b1;
      end else begin
        wr_write = 1'b0;
      end
      step();
      checks++;
      if (wr_waitrequest !== (k < 16)) begin
        errors++;
        $display("FAIL clear_sweep edge %0d: waitreq=%b want %b", k, wr_waitrequest, (k < 16));
      end
    end
    wr_write = 1'b0;
    all_zero("clear_read");
  endtask

  task automatic test_reset_midsweep();
    wr_address = 5'd1; wr_writedata = 8'h44; wr_write = 1'b1;
    step();
    wr_write = 1'b0;
    clear = 1'b1;
    step();
    clear = 1'b0;
    repeat (4) step();
    reset_n = 1'b0;
    #1;
    checks++;
    if (wr_waitrequest !== 1'b1 || rd_readdata !== 16'h0) begin
      errors++;
      $display("FAIL midsweep_reset: waitreq=%b rd=%h want 1/0000", wr_waitrequest, rd_readdata);
    end
    @(negedge clk);
    reset_n = 1'b1;
    sweep_timing("midsweep_sweep");
    all_zero("midsweep_read");
  endtask

  task automatic test_outreg();
`ifdef DFA_STATE_RAM_MP_OUTREG_EN
    wr_address = 5'd9; wr_writedata = 8'h33; wr_write = 1'b1;
    step();
    wr_write = 1'b0;
    set_rd(2, 9);
    step();
    set_rd(9, 9);
    wr_address = 5'd2; wr_writedata = 8'h5A; wr_write = 1'b1;
    step();
    wr_write = 1'b0;
    checks++;
    if (rd_readdata !== 16'h335A) begin
      errors++;
      $display("FAIL outreg_late_bypass: rd=%h want 335A", rd_readdata);
    end
    set_rd(2, 9);
    step();
    checks++;
    if (rd_readdata !== 16'h3333) begin
      errors++;
      $display("FAIL outreg_latency2_pipe: rd=%h want 3333", rd_readdata);
    end
    step();
    checks++;
    if (rd_readdata !== 16'h335A) begin
      errors++;
      $display("FAIL outreg_old_value: rd=%h want 335A", rd_readdata);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_write_bypass();
    test_back_to_back();
    test_out_of_range();
    test_clear();
    test_reset_midsweep();
    test_outreg();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
